// File: rtl/rx_huge_page_ctrl.sv
// RX huge-page ring controller: turns data-trigger and page-close handshakes into
// TX memory writes, and closes each page with a qword-count descriptor at offset 0.
module rx_huge_page_ctrl #(
  parameter int PAGE_ADDR_W = 64,
  parameter int QW_CNT_W    = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PAGE_ADDR_W-1:0] huge_page_addr_1,
  input  logic [PAGE_ADDR_W-1:0] huge_page_addr_2,
  input  logic                   huge_page_status_1,
  input  logic                   huge_page_status_2,
  output logic                   huge_page_unlock_1,
  output logic                   huge_page_unlock_2,
  input  logic                   trigger_tlp,
  output logic                   trigger_tlp_ack,
  input  logic                   change_huge_page,
  input  logic                   send_last_tlp_change_huge_page,
  input  logic [4:0]             qwords_to_send,
  output logic                   change_huge_page_ack,
  output logic                   tlp_req,
  input  logic                   tlp_gnt,
  input  logic                   tlp_done,
  output logic [PAGE_ADDR_W-1:0] tlp_addr,
  output logic [4:0]             tlp_qwords,
  output logic                   tlp_is_desc,
  output logic [QW_CNT_W-1:0]    tlp_desc_qwords,
  output logic                   page_overflow_err
);

  typedef enum logic [3:0] {
    IDLE, READY, DATA_REQ, DATA_WAIT, DATA_ACK,
    LAST_REQ, LAST_WAIT, DESC_REQ, DESC_WAIT, CHG_ACK
  } state_t;

  // QWs 0..15 of each page are reserved; the descriptor sits at QW 0.
  localparam logic [QW_CNT_W-1:0] FIRST_QW = QW_CNT_W'(16);
  localparam logic [QW_CNT_W:0]   PAGE_QW  = (QW_CNT_W+1)'(1) << (QW_CNT_W-1);

  state_t                 state;
  logic                   cur_page;
  logic [QW_CNT_W-1:0]    offset;
  logic [4:0]             last_qw;
  logic [1:0]             status_q;

  logic                   close_req;
  logic                   page_ready;
  logic [PAGE_ADDR_W-1:0] base;
  logic [PAGE_ADDR_W-1:0] data_addr;
  logic [4:0]             req_len;
  logic                   req_ovf;
  logic [QW_CNT_W-1:0]    offset_after_last;

  assign close_req         = change_huge_page | send_last_tlp_change_huge_page;
  assign base              = cur_page ? huge_page_addr_2 : huge_page_addr_1;
  assign page_ready        = cur_page ? status_q[1] : status_q[0];
  assign data_addr         = base + PAGE_ADDR_W'({offset, 3'b000});
  assign req_len           = trigger_tlp ? 5'd16 : qwords_to_send;
  assign req_ovf           = ({1'b0, offset} + (QW_CNT_W+1)'(req_len)) > PAGE_QW;
  assign offset_after_last = offset + QW_CNT_W'(last_qw);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cur_page             <= 1'b0;
      offset               <= FIRST_QW;
      last_qw              <= '0;
      status_q             <= '0;
      tlp_req              <= 1'b0;
      tlp_is_desc          <= 1'b0;
      tlp_addr             <= '0;
      tlp_qwords           <= '0;
      tlp_desc_qwords      <= '0;
      trigger_tlp_ack      <= 1'b0;
      change_huge_page_ack <= 1'b0;
      huge_page_unlock_1   <= 1'b0;
      huge_page_unlock_2   <= 1'b0;
      page_overflow_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; a later assignment
      // to the same register in this block overrides the default pulse clear below.
      status_q           <= {huge_page_status_2, huge_page_status_1};
      huge_page_unlock_1 <= 1'b0;
      huge_page_unlock_2 <= 1'b0;

      unique case (state)
        IDLE: if (page_ready) state <= READY;

        READY: begin
          if (trigger_tlp || close_req) begin
            if (req_ovf && (trigger_tlp || send_last_tlp_change_huge_page))
              page_overflow_err <= 1'b1;
          end
          if (trigger_tlp) begin
            tlp_req     <= 1'b1;
            tlp_is_desc <= 1'b0;
            tlp_addr    <= data_addr;
            tlp_qwords  <= 5'd16;
            state       <= DATA_REQ;
          end else if (close_req && send_last_tlp_change_huge_page) begin
            last_qw     <= qwords_to_send;
            tlp_req     <= 1'b1;
            tlp_is_desc <= 1'b0;
            tlp_addr    <= data_addr;
            tlp_qwords  <= qwords_to_send;
            state       <= LAST_REQ;
          end else if (close_req) begin
            tlp_req         <= 1'b1;
            tlp_is_desc     <= 1'b1;
            tlp_addr        <= base;
            tlp_qwords      <= 5'd1;
            tlp_desc_qwords <= offset - FIRST_QW;
            state           <= DESC_REQ;
          end
        end

        DATA_REQ, DATA_WAIT: begin
          if (state == DATA_REQ && tlp_gnt) tlp_req <= 1'b0;
          if ((state == DATA_REQ && tlp_gnt) || state == DATA_WAIT) begin
            if (tlp_done) begin
              offset          <= offset + QW_CNT_W'(16);
              trigger_tlp_ack <= 1'b1;
              state           <= DATA_ACK;
            end else begin
              state <= DATA_WAIT;
            end
          end
        end

        DATA_ACK: if (!trigger_tlp) begin
          trigger_tlp_ack <= 1'b0;
          state           <= READY;
        end

        // Residual TLP completion chains straight into the descriptor request.
        LAST_REQ, LAST_WAIT: begin
          if (state == LAST_REQ && tlp_gnt) tlp_req <= 1'b0;
          if ((state == LAST_REQ && tlp_gnt) || state == LAST_WAIT) begin
            if (tlp_done) begin
              offset          <= offset_after_last;
              tlp_req         <= 1'b1;
              tlp_is_desc     <= 1'b1;
              tlp_addr        <= base;
              tlp_qwords      <= 5'd1;
              tlp_desc_qwords <= offset_after_last - FIRST_QW;
              state           <= DESC_REQ;
            end else begin
              state <= LAST_WAIT;
            end
          end
        end

        DESC_REQ, DESC_WAIT: begin
          if (state == DESC_REQ && tlp_gnt) tlp_req <= 1'b0;
          if ((state == DESC_REQ && tlp_gnt) || state == DESC_WAIT) begin
            if (tlp_done) begin
              if (cur_page) huge_page_unlock_2 <= 1'b1;
              else          huge_page_unlock_1 <= 1'b1;
              cur_page             <= ~cur_page;
              offset               <= FIRST_QW;
              change_huge_page_ack <= 1'b1;
              state                <= CHG_ACK;
            end else begin
              state <= DESC_WAIT;
            end
          end
        end

        CHG_ACK: if (!close_req) begin
          change_huge_page_ack <= 1'b0;
          state                <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_huge_page_ctrl.sv
// Self-checking bench for rx_huge_page_ctrl: randomized TX handshake timing checked
// against a page/offset arithmetic model of the huge-page ring.
module tb_rx_huge_page_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] huge_page_addr_1 = 64'h1_0000_0000;
  logic [63:0] huge_page_addr_2 = 64'h2_8000_0000;
  logic        huge_page_status_1 = 1'b0, huge_page_status_2 = 1'b0;
  logic        huge_page_unlock_1, huge_page_unlock_2;
  logic        trigger_tlp = 1'b0, trigger_tlp_ack;
  logic        change_huge_page = 1'b0, send_last_tlp_change_huge_page = 1'b0;
  logic [4:0]  qwords_to_send = 5'd0;
  logic        change_huge_page_ack;
  logic        tlp_req, tlp_gnt = 1'b0, tlp_done = 1'b0;
  logic [63:0] tlp_addr;
  logic [4:0]  tlp_qwords;
  logic        tlp_is_desc;
  logic [18:0] tlp_desc_qwords;
  logic        page_overflow_err;

  rx_huge_page_ctrl #(.PAGE_ADDR_W(64), .QW_CNT_W(19)) dut (
    .clk(clk), .reset(reset),
    .huge_page_addr_1(huge_page_addr_1), .huge_page_addr_2(huge_page_addr_2),
    .huge_page_status_1(huge_page_status_1), .huge_page_status_2(huge_page_status_2),
    .huge_page_unlock_1(huge_page_unlock_1), .huge_page_unlock_2(huge_page_unlock_2),
    .trigger_tlp(trigger_tlp), .trigger_tlp_ack(trigger_tlp_ack),
    .change_huge_page(change_huge_page),
    .send_last_tlp_change_huge_page(send_last_tlp_change_huge_page),
    .qwords_to_send(qwords_to_send), .change_huge_page_ack(change_huge_page_ack),
    .tlp_req(tlp_req), .tlp_gnt(tlp_gnt), .tlp_done(tlp_done),
    .tlp_addr(tlp_addr), .tlp_qwords(tlp_qwords), .tlp_is_desc(tlp_is_desc),
    .tlp_desc_qwords(tlp_desc_qwords), .page_overflow_err(page_overflow_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: which page is open, where the next write lands, sticky error.
  logic [63:0] m_base [2];
  int          m_page;
  int          m_offset;
  logic        m_err;

  typedef struct packed {
    logic [63:0] addr;
    logic [4:0]  qwords;
    logic        is_desc;
    logic [18:0] desc_qw;
    logic        ok;
    logic        dropped;
  } txn_t;

  task automatic apply_reset();
    reset = 1'b1;
    trigger_tlp = 1'b0; change_huge_page = 1'b0; send_last_tlp_change_huge_page = 1'b0;
    qwords_to_send = 5'd0; tlp_gnt = 1'b0; tlp_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_page = 0; m_offset = 16; m_err = 1'b0;
    m_base[0] = huge_page_addr_1; m_base[1] = huge_page_addr_2;
  endtask

  // Acts as the TX engine: waits for a request, captures it, grants and completes it.
  task automatic tx_serve(input int gd, input int dd, output txn_t t);
    t = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tlp_req === 1'b1) begin t.ok = 1'b1; break; end
    end
    if (!t.ok) return;
    t.addr = tlp_addr; t.qwords = tlp_qwords; t.is_desc = tlp_is_desc; t.desc_qw = tlp_desc_qwords;
    repeat (gd) @(negedge clk);
    tlp_gnt = 1'b1; tlp_done = (dd == 0);
    @(negedge clk);
    tlp_gnt = 1'b0; tlp_done = 1'b0;
    t.dropped = (tlp_req === 1'b0);
    if (dd > 0) begin
      repeat (dd - 1) @(negedge clk);
      tlp_done = 1'b1;
      @(negedge clk);
      tlp_done = 1'b0;
    end
  endtask

  task automatic data_handshake(input int gd, input int dd, output txn_t t, output bit ack_ok);
    bit seen;
    trigger_tlp = 1'b1;
    tx_serve(gd, dd, t);
    ack_ok = 1'b0; seen = 1'b0;
    if (t.ok) begin
      for (int i = 0; i < 20; i++) begin
        if (trigger_tlp_ack === 1'b1) begin seen = 1'b1; break; end
        @(negedge clk);
      end
    end
    trigger_tlp = 1'b0;
    if (seen) begin
      for (int i = 0; i < 20; i++) begin
        if (trigger_tlp_ack === 1'b0) begin ack_ok = 1'b1; break; end
        @(negedge clk);
      end
    end
  endtask

  task automatic close_handshake(input bit with_last, input logic [4:0] res, input int gd,
                                 input int dd, output txn_t lt, output txn_t dt,
                                 output logic [1:0] unl_at, output logic [1:0] unl_after,
                                 output bit ack_ok);
    bit seen;
    lt = '0; dt = '0; unl_at = 2'b00; unl_after = 2'b11; ack_ok = 1'b0; seen = 1'b0;
    if (with_last) begin
      send_last_tlp_change_huge_page = 1'b1; qwords_to_send = res;
      tx_serve(gd, dd, lt);
    end else begin
      change_huge_page = 1'b1;
    end
    tx_serve(gd, dd, dt);
    if (dt.ok) begin
      for (int i = 0; i < 20; i++) begin
        if (change_huge_page_ack === 1'b1) begin seen = 1'b1; break; end
        @(negedge clk);
      end
    end
    if (seen) begin
      unl_at = {huge_page_unlock_2, huge_page_unlock_1};
      @(negedge clk);
      unl_after = {huge_page_unlock_2, huge_page_unlock_1};
    end
    change_huge_page = 1'b0; send_last_tlp_change_huge_page = 1'b0; qwords_to_send = 5'd0;
    if (seen) begin
      for (int i = 0; i < 20; i++) begin
        if (change_huge_page_ack === 1'b0) begin ack_ok = 1'b1; break; end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    bit saw_req;
    apply_reset();
    tests_run++;
    if ({tlp_req, tlp_is_desc, trigger_tlp_ack, change_huge_page_ack,
         huge_page_unlock_2, huge_page_unlock_1, page_overflow_err} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected 0000000", {tlp_req, tlp_is_desc, trigger_tlp_ack,
               change_huge_page_ack, huge_page_unlock_2, huge_page_unlock_1, page_overflow_err});
    end
    tests_run++;
    if ({tlp_addr, tlp_qwords, tlp_desc_qwords} !== '0) begin
      tests_failed++;
      $display("FAIL reset_fields: got addr=%h qw=%0d desc=%0d expected zeros", tlp_addr, tlp_qwords, tlp_desc_qwords);
    end
    // No page armed: a held trigger must not produce any request.
    trigger_tlp = 1'b1; saw_req = 1'b0;
    repeat (10) begin @(negedge clk); saw_req |= (tlp_req === 1'b1); end
    trigger_tlp = 1'b0;
    tests_run++;
    if (saw_req !== 1'b0) begin
      tests_failed++; $display("FAIL idle_no_req: got req=1 expected 0 while page not ready");
    end
    apply_reset();
  endtask

  task automatic test_data_tlps();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf; logic [63:0] exp;
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp = m_base[m_page] + 64'(m_offset) * 64'd8;
      data_handshake($urandom_range(0, 3), $urandom_range(0, 3), t, ack_ok);
      m_offset += 16;
      tests_run++;
      if ({t.ok, t.dropped, ack_ok} !== 3'b111) begin
        tests_failed++; $display("FAIL data_hs%0d: got ok/drop/ack=%b expected 111", k, {t.ok, t.dropped, ack_ok});
      end
      tests_run++;
      if ({t.addr, t.qwords, t.is_desc} !== {64'h1_0000_0080 + 64'(k) * 64'h80, 5'd16, 1'b0}) begin
        tests_failed++;
        $display("FAIL data_tlp%0d: got addr=%h qw=%0d desc=%b expected addr=%h qw=16 desc=0",
                 k, t.addr, t.qwords, t.is_desc, exp);
      end
    end
    close_handshake(1'b0, 5'd0, $urandom_range(0, 3), $urandom_range(0, 3), lt, dt, ua, uf, ack_ok);
    tests_run++;
    if ({dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw} !== {1'b1, m_base[m_page], 5'd1, 1'b1, 19'd48}) begin
      tests_failed++;
      $display("FAIL close_desc: got ok=%b addr=%h qw=%0d desc=%b cnt=%0d expected addr=%h qw=1 desc=1 cnt=48",
               dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw, m_base[m_page]);
    end
    tests_run++;
    if ({ua, uf, ack_ok} !== {2'b01, 2'b00, 1'b1}) begin
      tests_failed++; $display("FAIL close_unlock: got at=%b after=%b ack=%b expected 01 00 1", ua, uf, ack_ok);
    end
    m_page ^= 1; m_offset = 16;
  endtask

  task automatic test_send_last();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf;
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      data_handshake($urandom_range(0, 2), $urandom_range(0, 2), t, ack_ok);
      m_offset += 16;
    end
    close_handshake(1'b1, 5'd5, $urandom_range(0, 2), $urandom_range(0, 2), lt, dt, ua, uf, ack_ok);
    m_offset += 5;
    tests_run++;
    if ({lt.ok, lt.addr, lt.qwords, lt.is_desc} !== {1'b1, 64'h1_0000_0180, 5'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL last_tlp: got ok=%b addr=%h qw=%0d desc=%b expected addr=100000180 qw=5 desc=0",
               lt.ok, lt.addr, lt.qwords, lt.is_desc);
    end
    tests_run++;
    if ({dt.ok, dt.dropped, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw} !==
        {2'b11, 64'h1_0000_0000, 5'd1, 1'b1, 19'd37}) begin
      tests_failed++;
      $display("FAIL last_desc: got ok=%b addr=%h qw=%0d desc=%b cnt=%0d expected addr=100000000 qw=1 desc=1 cnt=37",
               dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw);
    end
    tests_run++;
    if ({ua, uf, ack_ok} !== {2'b01, 2'b00, 1'b1}) begin
      tests_failed++; $display("FAIL last_unlock: got at=%b after=%b ack=%b expected 01 00 1", ua, uf, ack_ok);
    end
    m_page ^= 1; m_offset = 16;
    data_handshake(0, 1, t, ack_ok);
    tests_run++;
    if ({t.ok, t.addr, t.qwords} !== {1'b1, 64'h2_8000_0080, 5'd16}) begin
      tests_failed++; $display("FAIL page2_first: got addr=%h qw=%0d expected addr=280000080 qw=16", t.addr, t.qwords);
    end
    m_offset += 16;
  endtask

  task automatic test_empty_close();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf;
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    close_handshake(1'b0, 5'd0, 0, 0, lt, dt, ua, uf, ack_ok);
    tests_run++;
    if ({dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw} !== {1'b1, m_base[0], 5'd1, 1'b1, 19'd0}) begin
      tests_failed++;
      $display("FAIL empty_desc: got ok=%b addr=%h qw=%0d desc=%b cnt=%0d expected first request desc at %h cnt=0",
               dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw, m_base[0]);
    end
    tests_run++;
    if ({ua, uf, ack_ok} !== {2'b01, 2'b00, 1'b1}) begin
      tests_failed++; $display("FAIL empty_unlock: got at=%b after=%b ack=%b expected 01 00 1", ua, uf, ack_ok);
    end
    m_page = 1; m_offset = 16;
    data_handshake(1, 0, t, ack_ok);
    tests_run++;
    if ({t.ok, ack_ok, t.addr} !== {2'b11, m_base[1] + 64'h80}) begin
      tests_failed++; $display("FAIL empty_toggle: got addr=%h ack=%b expected addr=%h ack=1", t.addr, ack_ok, m_base[1] + 64'h80);
    end
    m_offset += 16;
  endtask

  task automatic test_status_wait();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf; bit saw_req; int lat;
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b0;
    close_handshake(1'b0, 5'd0, 0, 0, lt, dt, ua, uf, ack_ok);
    m_page = 1; m_offset = 16;
    trigger_tlp = 1'b1; saw_req = 1'b0;
    repeat (20) begin @(negedge clk); saw_req |= (tlp_req === 1'b1); end
    tests_run++;
    if (saw_req !== 1'b0) begin
      tests_failed++; $display("FAIL status_block: got req=1 expected 0 while page 2 not armed");
    end
    huge_page_status_2 = 1'b1; lat = 99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tlp_req === 1'b1) begin lat = i + 1; break; end
    end
    tests_run++;
    if (lat > 3) begin
      tests_failed++; $display("FAIL status_latency: got %0d cycles expected <= 3", lat);
    end
    data_handshake(0, 0, t, ack_ok);
    tests_run++;
    if ({t.ok, ack_ok, t.addr, t.qwords} !== {2'b11, 64'h2_8000_0080, 5'd16}) begin
      tests_failed++; $display("FAIL status_tlp: got addr=%h qw=%0d ack=%b expected addr=280000080 qw=16 ack=1", t.addr, t.qwords, ack_ok);
    end
    m_offset += 16;
  endtask

  task automatic test_reset_mid_tlp();
    txn_t t; bit ack_ok; bit saw_req, saw_ack;
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    data_handshake(0, 0, t, ack_ok);
    m_offset += 16;
    trigger_tlp = 1'b1; saw_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tlp_req === 1'b1) begin saw_req = 1'b1; break; end
    end
    tests_run++;
    if (saw_req !== 1'b1) begin
      tests_failed++; $display("FAIL midtlp_req: got no request expected one");
    end
    tlp_gnt = 1'b1;
    @(negedge clk);
    tlp_gnt = 1'b0;
    @(negedge clk);
    reset = 1'b1; trigger_tlp = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({tlp_req, tlp_is_desc, trigger_tlp_ack, change_huge_page_ack, huge_page_unlock_2,
         huge_page_unlock_1, page_overflow_err, tlp_addr, tlp_qwords, tlp_desc_qwords} !== '0) begin
      tests_failed++;
      $display("FAIL midtlp_reset: got req=%b ack=%b addr=%h qw=%0d expected all zero",
               tlp_req, trigger_tlp_ack, tlp_addr, tlp_qwords);
    end
    @(negedge clk);
    reset = 1'b0;
    m_page = 0; m_offset = 16; m_err = 1'b0;
    tlp_done = 1'b1;
    @(negedge clk);
    tlp_done = 1'b0; saw_ack = 1'b0;
    repeat (5) begin @(negedge clk); saw_ack |= (trigger_tlp_ack === 1'b1) | (change_huge_page_ack === 1'b1); end
    tests_run++;
    if (saw_ack !== 1'b0) begin
      tests_failed++; $display("FAIL late_done: got ack=1 expected late tlp_done ignored");
    end
    data_handshake(0, 2, t, ack_ok);
    tests_run++;
    if ({t.ok, ack_ok, t.addr} !== {2'b11, 64'h1_0000_0080}) begin
      tests_failed++; $display("FAIL after_reset_tlp: got addr=%h ack=%b expected addr=100000080 ack=1", t.addr, ack_ok);
    end
    m_offset += 16;
  endtask

  task automatic test_random();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf; logic [63:0] exp; int r; logic [4:0] res;
    huge_page_addr_1 = {$urandom(), 11'($urandom_range(0, 2047)), 21'd0};
    huge_page_addr_2 = {$urandom(), 11'($urandom_range(0, 2047)), 21'd0};
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    for (int op = 0; op < 40; op++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        exp = m_base[m_page] + 64'(m_offset) * 64'd8;
        data_handshake($urandom_range(0, 3), $urandom_range(0, 3), t, ack_ok);
        m_offset += 16;
        tests_run++;
        if ({t.ok, t.dropped, ack_ok, t.addr, t.qwords, t.is_desc} !== {3'b111, exp, 5'd16, 1'b0}) begin
          tests_failed++;
          $display("FAIL rnd_data op%0d: got ok/drop/ack=%b addr=%h qw=%0d desc=%b expected 111 addr=%h qw=16 desc=0",
                   op, {t.ok, t.dropped, ack_ok}, t.addr, t.qwords, t.is_desc, exp);
        end
      end else begin
        res = 5'($urandom_range(1, 15));
        exp = m_base[m_page] + 64'(m_offset) * 64'd8;
        close_handshake(r >= 8, res, $urandom_range(0, 3), $urandom_range(0, 3), lt, dt, ua, uf, ack_ok);
        if (r >= 8) begin
          tests_run++;
          if ({lt.ok, lt.addr, lt.qwords, lt.is_desc} !== {1'b1, exp, res, 1'b0}) begin
            tests_failed++;
            $display("FAIL rnd_last op%0d: got addr=%h qw=%0d expected addr=%h qw=%0d", op, lt.addr, lt.qwords, exp, res);
          end
          m_offset += int'(res);
        end
        tests_run++;
        if ({dt.ok, dt.addr, dt.qwords, dt.is_desc, dt.desc_qw} !==
            {1'b1, m_base[m_page], 5'd1, 1'b1, 19'(m_offset - 16)}) begin
          tests_failed++;
          $display("FAIL rnd_desc op%0d: got addr=%h cnt=%0d desc=%b expected addr=%h cnt=%0d desc=1",
                   op, dt.addr, dt.desc_qw, dt.is_desc, m_base[m_page], m_offset - 16);
        end
        tests_run++;
        if ({ua, uf, ack_ok} !== {(m_page == 0) ? 2'b01 : 2'b10, 2'b00, 1'b1}) begin
          tests_failed++; $display("FAIL rnd_unlock op%0d: got at=%b after=%b ack=%b page=%0d", op, ua, uf, ack_ok, m_page);
        end
        m_page ^= 1; m_offset = 16;
      end
    end
    tests_run++;
    if (page_overflow_err !== m_err) begin
      tests_failed++; $display("FAIL rnd_err: got %b expected %b", page_overflow_err, m_err);
    end
  endtask

  task automatic test_overflow();
    txn_t t, lt, dt; bit ack_ok; logic [1:0] ua, uf; logic [63:0] exp;
    huge_page_addr_1 = 64'h1_0000_0000; huge_page_addr_2 = 64'h2_8000_0000;
    apply_reset();
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    // Fill page 1 exactly to its end: the last TLP ends at QW 2^18, which is legal.
    while (m_offset + 16 <= 262144) begin
      exp = m_base[m_page] + 64'(m_offset) * 64'd8;
      data_handshake(0, 0, t, ack_ok);
      m_offset += 16;
      tests_run++;
      if ({t.ok, ack_ok, t.addr} !== {2'b11, exp}) begin
        tests_failed++; $display("FAIL fill_tlp: got addr=%h ack=%b expected addr=%h", t.addr, ack_ok, exp);
      end
    end
    tests_run++;
    if (page_overflow_err !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_boundary: got err=%b expected 0 at offset %h", page_overflow_err, m_offset);
    end
    exp = m_base[m_page] + 64'(m_offset) * 64'd8;
    data_handshake(0, 0, t, ack_ok);
    m_offset += 16; m_err = 1'b1;
    tests_run++;
    if ({t.ok, t.addr, t.qwords, page_overflow_err} !== {1'b1, 64'h1_0020_0000, 5'd16, m_err}) begin
      tests_failed++;
      $display("FAIL ovf_set: got addr=%h qw=%0d err=%b expected addr=%h qw=16 err=1", t.addr, t.qwords, page_overflow_err, exp);
    end
    close_handshake(1'b0, 5'd0, 0, 0, lt, dt, ua, uf, ack_ok);
    tests_run++;
    if ({dt.ok, dt.desc_qw, page_overflow_err} !== {1'b1, 19'(m_offset - 16), 1'b1}) begin
      tests_failed++;
      $display("FAIL ovf_sticky: got cnt=%h err=%b expected cnt=%h err=1", dt.desc_qw, page_overflow_err, m_offset - 16);
    end
    apply_reset();
    tests_run++;
    if (page_overflow_err !== 1'b0) begin
      tests_failed++; $display("FAIL ovf_clear: got err=%b expected 0 after reset", page_overflow_err);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_data_tlps();
    test_send_last();
    test_empty_close();
    test_status_wait();
    test_reset_mid_tlp();
    test_random();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
